// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus of the data memory arbiter: one request/response lane
// per core. The arbiter is the slave; the cores (or a bench) are the master.
interface data_mem_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 8
);
   logic [N_REQ-1:0]             req_valid;
   logic [N_REQ-1:0][1:0]        req_op;
   logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [N_REQ-1:0][31:0]       req_wdata;
   logic [N_REQ-1:0]             req_ready;
   logic [N_REQ-1:0]             resp_valid;
   logic [N_REQ-1:0][31:0]       resp_rdata;

   modport master (
      output req_valid, req_op, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data memory (sync write, async read)
// between N_REQ cores. Each granted load, store or fetch-and-add finishes in
// the grant cycle; load/fetch-and-add data returns one cycle later.
module data_mem_arbiter #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 8   // word address width of the data memory
) (
   input  logic              clk,
   input  logic              reset,
   data_mem_arbiter_if.slave bus,
   output logic [ADDR_W-1:0] mem_addra,
   output logic [ADDR_W-1:0] mem_addrb,
   output logic [31:0]       mem_dina,
   output logic              mem_wea,
   input  logic [31:0]       mem_doutb
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_FAA   = 2'b10;

   logic [PTR_W-1:0]        ptr_r;
   logic [PTR_W-1:0]        ptr_next_s;
   logic [PTR_W-1:0]        gidx_s;
   logic                    found_s;
   logic                    grant_s;
   logic [1:0]              op_s;
   logic [ADDR_W-1:0]       addr_s;
   logic [31:0]             wdata_s;
   logic                    is_read_s;
   logic [N_REQ-1:0]        ready_s;
   logic [ADDR_W-1:0]       addr_hold_r;
   logic [N_REQ-1:0]        resp_valid_r;
   logic [N_REQ-1:0][31:0]  resp_rdata_r;

   // Round-robin scan from ptr_r: first valid requester wins.
   always_comb begin
      found_s = 1'b0;
      gidx_s  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found_s && bus.req_valid[(int'(ptr_r) + k) % N_REQ]) begin
            found_s = 1'b1;
            gidx_s  = PTR_W'((int'(ptr_r) + k) % N_REQ);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Nothing is accepted while reset is high.
   assign grant_s = found_s & ~reset;

   // Selected request fields; reserved op 11 falls through to load.
   always_comb begin
      op_s       = bus.req_op[gidx_s];
      addr_s     = bus.req_addr[gidx_s];
      wdata_s    = bus.req_wdata[gidx_s];
      is_read_s  = (op_s != OP_STORE);
      ptr_next_s = (gidx_s == PTR_W'(N_REQ - 1)) ? '0 : gidx_s + PTR_W'(1);
   end

   // Grant vector and memory drive for the granted operation.
   always_comb begin
      ready_s   = '0;
      mem_wea   = 1'b0;
      mem_dina  = wdata_s;
      mem_addra = addr_hold_r;
      if (grant_s) begin
         ready_s[gidx_s] = 1'b1;
         mem_addra       = addr_s;
         case (op_s)
            OP_STORE: begin
               mem_wea  = 1'b1;
               mem_dina = wdata_s;
            end
            OP_FAA: begin
               // Old value read and new value written in the same cycle,
               // which is what makes the add atomic. Carry is dropped.
               mem_wea  = 1'b1;
               mem_dina = mem_doutb + wdata_s;
            end
            default: begin
               mem_wea  = 1'b0;
               mem_dina = wdata_s;
            end
         endcase
      end else begin
         ready_s   = '0;
         mem_wea   = 1'b0;
         mem_addra = addr_hold_r;
      end
   end

   assign mem_addrb     = mem_addra;
   assign bus.req_ready = ready_s;
   // A response pending across a reset cycle is suppressed.
   assign bus.resp_valid = resp_valid_r & {N_REQ{~reset}};
   assign bus.resp_rdata = resp_rdata_r;

   // Priority pointer and held memory address advance on each grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_r       <= '0;
         addr_hold_r <= '0;
      end else if (grant_s) begin
         ptr_r       <= ptr_next_s;
         addr_hold_r <= addr_s;
      end else begin
         ptr_r       <= ptr_r;
         addr_hold_r <= addr_hold_r;
      end
   end

   // One-cycle response pulse carrying the pre-write memory value.
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_valid_r <= '0;
         resp_rdata_r <= '0;
      end else begin
         resp_valid_r <= '0;
         if (grant_s && is_read_s) begin
            resp_valid_r[gidx_s] <= 1'b1;
            resp_rdata_r[gidx_s] <= mem_doutb;
         end else begin
            resp_rdata_r <= resp_rdata_r;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with N_REQ=4 and a behavioural
// sync-write / async-read data memory.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  mem_addra;
   logic [7:0]  mem_addrb;
   logic [31:0] mem_dina;
   logic        mem_wea;
   logic [31:0] mem_doutb;

   logic [31:0] mem [0:255] = '{default: 32'h0};
   logic        bd_we = 1'b0;
   logic [7:0]  bd_addr = 8'h0;
   logic [31:0] bd_data = 32'h0;

   int errors = 0;
   int checks = 0;

   data_mem_arbiter_if #(.N_REQ(4), .ADDR_W(8)) bus ();

   data_mem_arbiter #(.N_REQ(4), .ADDR_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .mem_addra (mem_addra),
      .mem_addrb (mem_addrb),
      .mem_dina  (mem_dina),
      .mem_wea   (mem_wea),
      .mem_doutb (mem_doutb)
   );

   always #5 clk = ~clk;

   // Data memory: synchronous write, asynchronous read, plus bench backdoor.
   always @(posedge clk) begin
      if (mem_wea) mem[mem_addra] <= mem_dina;
      if (bd_we)   mem[bd_addr]   <= bd_data;
   end
   assign mem_doutb = mem[mem_addrb];

   task automatic idle();
      bus.req_valid = 4'b0000;
      bus.req_op    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bd_write(input logic [7:0] a, input logic [31:0] d);
      bd_addr = a;
      bd_data = d;
      bd_we   = 1'b1;
      step();
      bd_we   = 1'b0;
   endtask

   task automatic test_reset();
      bus.req_valid    = 4'b1001;
      bus.req_op[0]    = 2'b01;  bus.req_addr[0] = 8'h50; bus.req_wdata[0] = 32'h11111111;
      bus.req_op[3]    = 2'b00;  bus.req_addr[3] = 8'h50;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0000) begin $display("FAIL rst_ready: got %b want 0000", bus.req_ready); errors++; end
      checks++; if (mem_wea !== 1'b0) begin $display("FAIL rst_wea: got %b want 0", mem_wea); errors++; end
      checks++; if (bus.resp_valid !== 4'b0000) begin $display("FAIL rst_resp_valid: got %b want 0000", bus.resp_valid); errors++; end
      checks++; if (bus.resp_rdata !== 128'h0) begin $display("FAIL rst_resp_rdata: got %h want 0", bus.resp_rdata); errors++; end
      step();
      @(negedge clk);
      checks++; if (mem[8'h50] !== 32'h0) begin $display("FAIL rst_no_write: got %h want 0", mem[8'h50]); errors++; end
      step();
      reset = 1'b0;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0001) begin $display("FAIL rst_first_grant: got %b want 0001", bus.req_ready); errors++; end
      checks++; if (mem_wea !== 1'b1 || mem_addra !== 8'h50 || mem_dina !== 32'h11111111) begin
         $display("FAIL rst_store_drive: wea=%b addra=%h dina=%h want 1/50/11111111", mem_wea, mem_addra, mem_dina); errors++; end
      step();
      bus.req_valid[0] = 1'b0;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b1000) begin $display("FAIL rst_second_grant: got %b want 1000", bus.req_ready); errors++; end
      checks++; if (bus.resp_valid !== 4'b0000) begin $display("FAIL rst_store_noresp: got %b want 0000", bus.resp_valid); errors++; end
      step();
      idle();
      @(negedge clk);
      checks++; if (bus.resp_valid !== 4'b1000 || bus.resp_rdata[3] !== 32'h11111111) begin
         $display("FAIL rst_load_resp: valid=%b rdata=%h want 1000/11111111", bus.resp_valid, bus.resp_rdata[3]); errors++; end
   endtask

   task automatic test_store_load();
      step();
      bus.req_valid = 4'b0001;
      bus.req_op[0] = 2'b01; bus.req_addr[0] = 8'h10; bus.req_wdata[0] = 32'hDEADBEEF;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0001 || mem_wea !== 1'b1) begin
         $display("FAIL sl_store: ready=%b wea=%b want 0001/1", bus.req_ready, mem_wea); errors++; end
      step();
      bus.req_op[0] = 2'b00;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0001 || mem_wea !== 1'b0) begin
         $display("FAIL sl_load: ready=%b wea=%b want 0001/0", bus.req_ready, mem_wea); errors++; end
      checks++; if (bus.resp_valid !== 4'b0000) begin $display("FAIL sl_store_noresp: got %b want 0000", bus.resp_valid); errors++; end
      step();
      idle();
      @(negedge clk);
      checks++; if (bus.resp_valid !== 4'b0001 || bus.resp_rdata[0] !== 32'hDEADBEEF) begin
         $display("FAIL sl_resp: valid=%b rdata=%h want 0001/deadbeef", bus.resp_valid, bus.resp_rdata[0]); errors++; end
      step();
      @(negedge clk);
      checks++; if (bus.resp_valid !== 4'b0000) begin $display("FAIL sl_pulse: got %b want 0000", bus.resp_valid); errors++; end
      checks++; if (mem_addrb !== 8'h10 || mem_wea !== 1'b0) begin
         $display("FAIL sl_addr_hold: addrb=%h wea=%b want 10/0", mem_addrb, mem_wea); errors++; end
   endtask

   task automatic test_round_robin();
      int          exp_g [6]  = '{0, 1, 2, 3, 0, 1};
      logic [31:0] exp_d [6]  = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0, 32'hA1};
      logic [3:0]  one = 4'b0001;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         bus.req_op[i]   = 2'b00;
         bus.req_addr[i] = 8'h40 + 8'(i);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++; if (bus.req_ready !== (one << exp_g[c])) begin
            $display("FAIL rr_grant%0d: got %b want %b", c, bus.req_ready, one << exp_g[c]); errors++; end
         if (c > 0) begin
            checks++; if (bus.resp_valid !== (one << exp_g[c-1]) || bus.resp_rdata[exp_g[c-1]] !== exp_d[c-1]) begin
               $display("FAIL rr_resp%0d: valid=%b rdata=%h want %b/%h", c, bus.resp_valid,
                        bus.resp_rdata[exp_g[c-1]], one << exp_g[c-1], exp_d[c-1]); errors++; end
         end
         step();
      end
      idle();
      @(negedge clk);
      checks++; if (bus.resp_valid !== 4'b0010 || bus.resp_rdata[1] !== 32'hA1) begin
         $display("FAIL rr_last_resp: valid=%b rdata=%h want 0010/a1", bus.resp_valid, bus.resp_rdata[1]); errors++; end
   endtask

   task automatic test_faa_contention();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.req_valid = 4'b0110;
      for (int i = 1; i < 3; i++) begin
         bus.req_op[i] = 2'b10; bus.req_addr[i] = 8'h20; bus.req_wdata[i] = 32'h1;
      end
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0010 || mem_wea !== 1'b1 || mem_dina !== 32'h6) begin
         $display("FAIL faa_first: ready=%b wea=%b dina=%h want 0010/1/6", bus.req_ready, mem_wea, mem_dina); errors++; end
      step();
      bus.req_valid = 4'b0100;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0100 || mem_dina !== 32'h7) begin
         $display("FAIL faa_second: ready=%b dina=%h want 0100/7", bus.req_ready, mem_dina); errors++; end
      checks++; if (bus.resp_valid !== 4'b0010 || bus.resp_rdata[1] !== 32'h5) begin
         $display("FAIL faa_resp1: valid=%b rdata=%h want 0010/5", bus.resp_valid, bus.resp_rdata[1]); errors++; end
      step();
      bus.req_valid = 4'b0001;
      bus.req_op[0] = 2'b00; bus.req_addr[0] = 8'h20;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0001) begin $display("FAIL faa_load_grant: got %b want 0001", bus.req_ready); errors++; end
      checks++; if (bus.resp_valid !== 4'b0100 || bus.resp_rdata[2] !== 32'h6) begin
         $display("FAIL faa_resp2: valid=%b rdata=%h want 0100/6", bus.resp_valid, bus.resp_rdata[2]); errors++; end
      step();
      idle();
      @(negedge clk);
      checks++; if (bus.resp_valid !== 4'b0001 || bus.resp_rdata[0] !== 32'h7) begin
         $display("FAIL faa_final_load: valid=%b rdata=%h want 0001/7", bus.resp_valid, bus.resp_rdata[0]); errors++; end
      checks++; if (bus.resp_rdata[1] !== 32'h5) begin $display("FAIL faa_rdata_hold: got %h want 5", bus.resp_rdata[1]); errors++; end
   endtask

   task automatic test_faa_wrap();
      step();
      bus.req_valid = 4'b1000;
      bus.req_op[3] = 2'b10; bus.req_addr[3] = 8'h30; bus.req_wdata[3] = 32'h2;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b1000 || mem_wea !== 1'b1 || mem_dina !== 32'h1) begin
         $display("FAIL wrap_drive: ready=%b wea=%b dina=%h want 1000/1/1", bus.req_ready, mem_wea, mem_dina); errors++; end
      step();
      idle();
      bus.req_valid = 4'b0100;
      bus.req_op[2] = 2'b11; bus.req_addr[2] = 8'h30; bus.req_wdata[2] = 32'h55;
      @(negedge clk);
      checks++; if (bus.resp_valid !== 4'b1000 || bus.resp_rdata[3] !== 32'hFFFFFFFF) begin
         $display("FAIL wrap_resp: valid=%b rdata=%h want 1000/ffffffff", bus.resp_valid, bus.resp_rdata[3]); errors++; end
      checks++; if (mem[8'h30] !== 32'h1) begin $display("FAIL wrap_mem: got %h want 1", mem[8'h30]); errors++; end
      checks++; if (bus.req_ready !== 4'b0100 || mem_wea !== 1'b0) begin
         $display("FAIL rsvd_as_load: ready=%b wea=%b want 0100/0", bus.req_ready, mem_wea); errors++; end
      step();
      idle();
      @(negedge clk);
      checks++; if (bus.resp_valid !== 4'b0100 || bus.resp_rdata[2] !== 32'h1) begin
         $display("FAIL rsvd_resp: valid=%b rdata=%h want 0100/1", bus.resp_valid, bus.resp_rdata[2]); errors++; end
   endtask

   task automatic test_reset_mid();
      step();
      bus.req_valid = 4'b0010;
      bus.req_op[1] = 2'b00; bus.req_addr[1] = 8'h10;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0010) begin $display("FAIL mid_grant: got %b want 0010", bus.req_ready); errors++; end
      step();
      idle();
      reset = 1'b1;
      @(negedge clk);
      checks++; if (bus.resp_valid !== 4'b0000) begin $display("FAIL mid_resp_in_reset: got %b want 0000", bus.resp_valid); errors++; end
      step();
      reset = 1'b0;
      @(negedge clk);
      checks++; if (bus.resp_valid !== 4'b0000) begin $display("FAIL mid_resp_after: got %b want 0000", bus.resp_valid); errors++; end
      checks++; if (bus.resp_rdata !== 128'h0) begin $display("FAIL mid_rdata_cleared: got %h want 0", bus.resp_rdata); errors++; end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      step();
      bd_write(8'h20, 32'h5);
      bd_write(8'h30, 32'hFFFFFFFF);
      for (int i = 0; i < 4; i++) bd_write(8'h40 + 8'(i), 32'hA0 + 32'(i));
      test_reset();
      test_store_load();
      test_round_robin();
      test_faa_contention();
      test_faa_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
